// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand select, ALU, HI/LO and a radix-2 restoring divider
`ifndef StallBus
`define StallBus 6
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif
`ifndef ID_TO_EX_WD
`define ID_TO_EX_WD 159
`endif
`ifndef EX_TO_MEM_WD
`define EX_TO_MEM_WD 76
`endif
`ifndef EX_TO_ID_WD
`define EX_TO_ID_WD 38
`endif

module ex_stage (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`StallBus-1:0]     stall,
  output logic                     stallreq_for_ex,
  input  logic [`ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [`EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [`EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                     data_sram_en,
  output logic [3:0]               data_sram_wen,
  output logic [31:0]              data_sram_addr,
  output logic [31:0]              data_sram_wdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  logic [`ID_TO_EX_WD-1:0] ex_q;
  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we_in, sel_rf_res;
  logic [4:0]  rf_waddr_in;

  always_ff @(posedge clk) begin
    if (rst)
      ex_q <= '0;
    else if (stall[2] == `Stop && stall[3] == `NoStop)
      ex_q <= '0;
    else if (stall[3] == `NoStop)
      ex_q <= id_to_ex_bus;
  end

  assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we_in,
          rf_waddr_in, sel_rf_res, rdata1, rdata2} = ex_q;

  logic r_type, is_div, is_divu, is_mfhi, is_mflo;
  assign r_type  = (inst[31:26] == 6'b000000);
  assign is_div  = r_type && (inst[5:0] == 6'b011010);
  assign is_divu = r_type && (inst[5:0] == 6'b011011);
  assign is_mfhi = r_type && (inst[5:0] == 6'b010000);
  assign is_mflo = r_type && (inst[5:0] == 6'b010010);

  logic [31:0] src1, src2, alu_res;
  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

  // alu_op is one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}
  always_comb begin
    alu_res = 32'b0;
    case (1'b1)
      alu_op[11]: alu_res = src1 + src2;
      alu_op[10]: alu_res = src1 - src2;
      alu_op[9]:  alu_res = {31'b0, $signed(src1) < $signed(src2)};
      alu_op[8]:  alu_res = {31'b0, src1 < src2};
      alu_op[7]:  alu_res = src1 & src2;
      alu_op[6]:  alu_res = ~(src1 | src2);
      alu_op[5]:  alu_res = src1 | src2;
      alu_op[4]:  alu_res = src1 ^ src2;
      alu_op[3]:  alu_res = src2 << src1[4:0];
      alu_op[2]:  alu_res = src2 >> src1[4:0];
      alu_op[1]:  alu_res = $signed(src2) >>> src1[4:0];
      alu_op[0]:  alu_res = {src2[15:0], 16'b0};
      default:    alu_res = 32'b0;
    endcase
  end

  div_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] hi, lo, dq, dvs, rem;
  logic        neg_q, neg_r;

  // dq shifts dividend bits out of the top while quotient bits enter at the bottom
  logic [33:0] diff;
  logic        ge;
  logic [31:0] rem_nx, dq_nx;
  assign diff   = {1'b0, rem, dq[31]} - {2'b0, dvs};
  assign ge     = ~diff[33];
  assign rem_nx = ge ? diff[31:0] : {rem[30:0], dq[31]};
  assign dq_nx  = {dq[30:0], ge};

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  assign a_neg = is_div & rdata1[31];
  assign b_neg = is_div & rdata2[31];
  assign a_mag = a_neg ? -rdata1 : rdata1;
  assign b_mag = b_neg ? -rdata2 : rdata2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      hi    <= 32'b0;
      lo    <= 32'b0;
      dq    <= 32'b0;
      dvs   <= 32'b0;
      rem   <= 32'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_div || is_divu) begin
          dq    <= a_mag;
          dvs   <= b_mag;
          rem   <= 32'b0;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= 5'd0;
          state <= BUSY;
        end
        BUSY: begin
          dq  <= dq_nx;
          rem <= rem_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi    <= neg_r ? -rem_nx : rem_nx;
            // divide by zero keeps the all-ones quotient regardless of sign
            lo    <= (neg_q && dvs != 32'b0) ? -dq_nx : dq_nx;
            state <= DONE;
          end
        end
        DONE: if (stall[3] == `NoStop) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stallreq_for_ex = ((state == IDLE) && (is_div || is_divu)) || (state == BUSY);

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  assign rf_we     = rf_we_in | is_mfhi | is_mflo;
  assign rf_waddr  = (is_mfhi || is_mflo) ? inst[15:11] : rf_waddr_in;
  assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);

  assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_id_bus    = {rf_we, rf_waddr, ex_result};
  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = rdata2;

  logic unused;
  assign unused = ^{stall[5:4], stall[1:0], inst[25:16]};

endmodule
